rle_run_encoder: RTL

- Converts a raster-order pixel stream of one image frame into run-length records {start index, end index, color}.
- A run is a maximal span of consecutive linear pixel indices (row*IMG_WIDTH+col) that share one color.
- Produces the run tables consumed by our range-compare image ROMs; sits between the capture/frame source and the ROM-generation/storage path.
- Valid/ready handshake on both sides; single-entry output register with backpressure.

---
 rtl/rle_run_encoder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/rle_run_encoder.sv
// rle_run_encoder: turns one raster-order frame of pixels into run-length
// records {start index, end index, color}. A run ends on a color change or at
// the final pixel of the frame. The output is a single record register with
// backpressure, and a record can be handed off and reloaded in the same cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid never depends on ready. While valid is high and ready is low,
// the payload holds steady. valid only drops after a transfer, or on reset.
module rle_run_encoder #(
    parameter int IMG_WIDTH  = 584,
    parameter int IMG_HEIGHT = 167,
    parameter int COLOR_W    = 12,
    parameter int IDX_W      = 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_valid,
    input  logic [COLOR_W-1:0] pixel_color,
    output logic               pixel_ready,
    output logic               run_valid,
    input  logic               run_ready,
    output logic [IDX_W-1:0]   run_start,
    output logic [IDX_W-1:0]   run_end,
    output logic [COLOR_W-1:0] run_color,
    output logic               run_last,
    output logic [IDX_W-1:0]   run_count,
    output logic               frame_done
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   cur_start_q, cur_start_d;
    logic [COLOR_W-1:0] cur_color_q, cur_color_d;
    logic               run_valid_q, run_valid_d;
    logic [IDX_W-1:0]   run_start_q, run_start_d;
    logic [IDX_W-1:0]   run_end_q, run_end_d;
    logic [COLOR_W-1:0] run_color_q, run_color_d;
    logic               run_last_q, run_last_d;
    logic [IDX_W-1:0]   run_count_q, run_count_d;
    logic               frame_done_q, frame_done_d;

    logic slot_free;
    logic handoff;
    logic accept;
    logic is_last;
    logic same_color;

    // The output slot can take a new record when empty or when its current one leaves this cycle.
    always_comb begin
        slot_free  = !run_valid_q || run_ready;
        handoff    = run_valid_q && run_ready;
        is_last    = (idx_q == LAST_IDX);
        same_color = (pixel_color == cur_color_q);
        pixel_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE:  pixel_ready = 1'b1;
                S_ACCUM: pixel_ready = slot_free;
                default: pixel_ready = 1'b0;
            endcase
        end
        accept = pixel_valid && pixel_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ACCUM on the first pixel, ACCUM -> FLUSH on the last pixel,
    // FLUSH -> DRAIN once the final record is loaded, DRAIN -> IDLE once it is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ACCUM;
            S_ACCUM: if (accept && is_last) state_d = S_FLUSH;
            S_FLUSH: if (slot_free) state_d = S_DRAIN;
            S_DRAIN: if (handoff) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: run tracking, output record loads, handoff bookkeeping.
    always_comb begin
        idx_d        = idx_q;
        cur_start_d  = cur_start_q;
        cur_color_d  = cur_color_q;
        run_valid_d  = run_valid_q;
        run_start_d  = run_start_q;
        run_end_d    = run_end_q;
        run_color_d  = run_color_q;
        run_last_d   = run_last_q;
        run_count_d  = run_count_q;
        frame_done_d = (state_q == S_DRAIN) && handoff;

        // A departing record empties the slot; a load below may refill it in the same cycle.
        if (handoff) begin
            run_valid_d = 1'b0;
            run_count_d = run_count_q + IDX_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cur_color_d = pixel_color;
                    cur_start_d = '0;
                    idx_d       = IDX_W'(1);
                    run_count_d = '0;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (!same_color) begin
                        // Close the previous run at idx-1 and open a new one at idx.
                        run_valid_d = 1'b1;
                        run_start_d = cur_start_q;
                        run_end_d   = idx_q - IDX_W'(1);
                        run_color_d = cur_color_q;
                        run_last_d  = 1'b0;
                        cur_start_d = idx_q;
                        cur_color_d = pixel_color;
                    end
                    if (!is_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    run_valid_d = 1'b1;
                    run_start_d = cur_start_q;
                    run_end_d   = LAST_IDX;
                    run_color_d = cur_color_q;
                    run_last_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q        <= '0;
            cur_start_q  <= '0;
            cur_color_q  <= '0;
            run_valid_q  <= 1'b0;
            run_start_q  <= '0;
            run_end_q    <= '0;
            run_color_q  <= '0;
            run_last_q   <= 1'b0;
            run_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            cur_start_q  <= cur_start_d;
            cur_color_q  <= cur_color_d;
            run_valid_q  <= run_valid_d;
            run_start_q  <= run_start_d;
            run_end_q    <= run_end_d;
            run_color_q  <= run_color_d;
            run_last_q   <= run_last_d;
            run_count_q  <= run_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign run_valid  = run_valid_q;
    assign run_start  = run_start_q;
    assign run_end    = run_end_q;
    assign run_color  = run_color_q;
    assign run_last   = run_last_q;
    assign run_count  = run_count_q;
    assign frame_done = frame_done_q;

endmodule
